// File: rtl/pparb_pkg.sv
// Shared types and constants for the pport transmit arbiter.
package pparb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } pparb_state_t;

  localparam logic [7:0] PP_NL = 8'h0a;
  localparam logic [7:0] PP_CR = 8'h0d;

endpackage

// File: rtl/pptx_arbiter_if.sv
// Source-side and transmitter-side signals of pptx_arbiter, bundled for port passing.
// slave = the arbiter, master = the environment (sources plus pport transmitter).
interface pptx_arbiter_if #(
  parameter int NSRC = 2
);
  // Source k: byte on i_data[8k+7:8k] is taken on a cycle with i_stb[k] && !o_busy[k].
  // Transmitter: byte is taken on a cycle with o_tx_stb && !i_tx_busy.
  logic [NSRC-1:0]   i_stb;
  logic [8*NSRC-1:0] i_data;
  logic [NSRC-1:0]   o_busy;
  logic [NSRC-1:0]   o_grant;
  logic              o_tx_stb;
  logic [7:0]        o_tx_data;
  logic              i_tx_busy;

  modport slave (
    input  i_stb, i_data, i_tx_busy,
    output o_busy, o_grant, o_tx_stb, o_tx_data
  );

  modport master (
    output i_stb, i_data, i_tx_busy,
    input  o_busy, o_grant, o_tx_stb, o_tx_data
  );
endinterface

// File: rtl/pparb_rrpick.sv
// Combinational round-robin picker: first requester after the last owner,
// searching upward with wraparound, so the last owner has the lowest priority.
module pparb_rrpick
  import pparb_pkg::*;
#(
  parameter  int NSRC = 2,
  localparam int IW   = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NSRC-1:0] gnt,
  output logic            valid
);

  int idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NSRC; i++) begin
      idx = (int'(last) + i) % NSRC;
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pptx_arbiter.sv
// Line-granular round-robin arbiter sharing the pport transmit channel among NSRC sources.
// Optional idle-owner release is built when PPARB_TIMEOUT_EN is defined.
module pptx_arbiter
  import pparb_pkg::*;
#(
  parameter int NSRC    = 2,
  parameter int MAXLEN  = 80,
  parameter int TIMEOUT = 1024
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  pptx_arbiter_if.slave bus,
  output pparb_state_t  o_state
);

  localparam int IW = $clog2(NSRC);
  localparam int CW = $clog2(MAXLEN + 1);

  if (NSRC < 2 || NSRC > 8 || MAXLEN < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("pptx_arbiter: parameter out of range");
  end

  pparb_state_t    state;
  logic [NSRC-1:0] grant;
  logic            tx_stb;
  logic [7:0]      tx_data;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   last;

  logic [NSRC-1:0] pick_gnt;
  logic            pick_valid;
  logic [7:0]      owner_byte;
  logic            owner_stb;
  logic [IW-1:0]   owner_idx;
  logic            free;
  logic            accept;
  logic            line_end;

  pparb_rrpick #(.NSRC(NSRC)) u_pick (
    .req   (bus.i_stb),
    .last  (last),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    owner_byte = '0;
    owner_idx  = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (grant[k]) begin
        owner_byte = owner_byte | bus.i_data[8*k +: 8];
        owner_idx  = IW'(k);
      end
    end
  end

  assign owner_stb = |(bus.i_stb & grant);
  assign free      = !tx_stb || !bus.i_tx_busy;
  assign accept    = (state == OWN) && free && owner_stb;
  // The byte that fills the MAXLEN-th slot also ends the grant.
  assign line_end  = (owner_byte == PP_NL) || (owner_byte == PP_CR) ||
                     (cnt >= CW'(MAXLEN - 1));

  assign bus.o_busy    = ~(((state == OWN) && free) ? grant : '0);
  assign bus.o_grant   = grant;
  assign bus.o_tx_stb  = tx_stb;
  assign bus.o_tx_data = tx_data;
  assign o_state       = state;

`ifdef PPARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      grant    <= '0;
      tx_stb   <= 1'b0;
      tx_data  <= '0;
      cnt      <= '0;
      last     <= IW'(NSRC - 1);
`ifdef PPARB_TIMEOUT_EN
      idle_cnt <= '0;
`endif
    end else begin
      // The output register drains independently of the arbitration state.
      if (accept) begin
        tx_stb  <= 1'b1;
        tx_data <= owner_byte;
      end else if (!bus.i_tx_busy) begin
        tx_stb  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant    <= pick_gnt;
            cnt      <= '0;
            state    <= OWN;
`ifdef PPARB_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end
        end
        OWN: begin
          if (accept) begin
            cnt <= (cnt == CW'(MAXLEN)) ? cnt : cnt + 1'b1;
`ifdef PPARB_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            if (line_end) begin
              state <= IDLE;
              grant <= '0;
              last  <= owner_idx;
            end
          end
`ifdef PPARB_TIMEOUT_EN
          else if (!owner_stb) begin
            if (idle_cnt >= TW'(TIMEOUT - 1)) begin
              state <= IDLE;
              grant <= '0;
              last  <= owner_idx;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pptx_arbiter.sv
// Self-checking bench for pptx_arbiter: directed steps plus randomized line streams
// compared against a round-robin line model.
module tb_pptx_arbiter;
  import pparb_pkg::*;

  localparam int NSRC   = 2;
  localparam int MAXLEN = 80;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pptx_arbiter_if #(.NSRC(NSRC)) bus ();
  pparb_state_t state;

  pptx_arbiter #(.NSRC(NSRC), .MAXLEN(MAXLEN), .TIMEOUT(1024)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus),
    .o_state   (state)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] s0_q[$];
  logic [7:0] s1_q[$];
  logic [7:0] exp_q[$];
  int         exp_owner_q[$];
  int         model_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_sources();
    bus.i_stb[0]     = (s0_q.size() != 0);
    bus.i_data[7:0]  = (s0_q.size() != 0) ? s0_q[0] : 8'h00;
    bus.i_stb[1]     = (s1_q.size() != 0);
    bus.i_data[15:8] = (s1_q.size() != 0) ? s1_q[0] : 8'h00;
  endtask

  task automatic add_line(input int src, input int len, input logic [7:0] term);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(8'h20, 8'h7e));
      if (src == 0) s0_q.push_back(b); else s1_q.push_back(b);
    end
    if (term != 8'h00) begin
      if (src == 0) s0_q.push_back(term); else s1_q.push_back(term);
    end
  endtask

  // Splits each source's byte stream into grants (terminator or MAXLEN bytes) and
  // orders the grants round-robin, starting after model_last.
  task automatic model_build();
    logic [7:0] a[$];
    logic [7:0] b[$];
    logic [7:0] byt;
    int src;
    int n;
    a = s0_q;
    b = s1_q;
    while (a.size() != 0 || b.size() != 0) begin
      if (model_last == 0) src = (b.size() != 0) ? 1 : 0;
      else                 src = (a.size() != 0) ? 0 : 1;
      n = 0;
      do begin
        byt = (src == 0) ? a.pop_front() : b.pop_front();
        exp_q.push_back(byt);
        n++;
      end while (byt != PP_NL && byt != PP_CR && n < MAXLEN &&
                 ((src == 0) ? a.size() : b.size()) != 0);
      exp_owner_q.push_back(src);
      model_last = src;
    end
  endtask

  task automatic run_stream(input int busy_pct, input int stall_at, input int budget);
    logic [NSRC-1:0] prev_grant;
    logic [NSRC-1:0] exp_busy;
    logic            prev_hold;
    logic [7:0]      prev_data;
    int takes;
    int stall_left;
    int cyc;
    int idx;
    prev_grant = bus.o_grant;
    prev_hold  = 1'b0;
    prev_data  = 8'h00;
    takes      = 0;
    stall_left = 0;
    cyc        = 0;
    while ((exp_q.size() != 0 || s0_q.size() != 0 || s1_q.size() != 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (stall_left == 0 && stall_at >= 0 && takes == stall_at) begin
        stall_left = 5;
        stall_at   = -1;
      end
      if (stall_left > 0) begin
        bus.i_tx_busy = 1'b1;
        stall_left--;
      end else begin
        bus.i_tx_busy = ($urandom_range(99) < busy_pct);
      end
      drive_sources();
      #1;
      check("grant_onehot", 32'($onehot0(bus.o_grant)), 1);
      if (bus.o_grant != 0 && prev_grant != 0)
        check("grant_no_switch", bus.o_grant, prev_grant);
      if (bus.o_grant != 0 && prev_grant == 0) begin
        idx = bus.o_grant[1] ? 1 : 0;
        if (exp_owner_q.size() == 0) check("grant_extra", idx, 32'hff);
        else check("grant_owner", idx, exp_owner_q.pop_front());
      end
      exp_busy = ~bus.o_grant | {NSRC{bus.o_tx_stb && bus.i_tx_busy}};
      check("busy", bus.o_busy, exp_busy);
      if (prev_hold) begin
        check("hold_stb", bus.o_tx_stb, 1);
        check("hold_data", bus.o_tx_data, prev_data);
      end
      if (bus.o_tx_stb && !bus.i_tx_busy) begin
        takes++;
        if (exp_q.size() == 0) check("tx_extra", bus.o_tx_data, 32'h100);
        else check("tx_byte", bus.o_tx_data, exp_q.pop_front());
      end
      if (bus.i_stb[0] && !bus.o_busy[0]) void'(s0_q.pop_front());
      if (bus.i_stb[1] && !bus.o_busy[1]) void'(s1_q.pop_front());
      prev_hold  = bus.o_tx_stb && bus.i_tx_busy;
      prev_data  = bus.o_tx_data;
      prev_grant = bus.o_grant;
    end
    check("stream_bytes_left", exp_q.size(), 0);
    check("stream_owners_left", exp_owner_q.size(), 0);
    check("stream_src_left", s0_q.size() + s1_q.size(), 0);
    bus.i_tx_busy = 1'b0;
    drive_sources();
  endtask

  initial begin
    int waited;
    bus.i_stb     = '0;
    bus.i_data    = '0;
    bus.i_tx_busy = 1'b0;
    model_last    = NSRC - 1;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_grant", bus.o_grant, 0);
    check("rst_tx_stb", bus.o_tx_stb, 0);
    check("rst_tx_data", bus.o_tx_data, 0);
    check("rst_busy", bus.o_busy, 2'b11);
    check("rst_state", state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    // "AB\n" from source 0 with exact cycle timing
    @(negedge clk);
    bus.i_stb[0] = 1'b1; bus.i_data[7:0] = 8'h41;
    #1 check("t1_idle_grant", bus.o_grant, 0);
    @(negedge clk); #1;
    check("t1_grant", bus.o_grant, 2'b01);
    check("t1_busy0", bus.o_busy[0], 0);
    check("t1_tx_stb_early", bus.o_tx_stb, 0);
    @(negedge clk);
    bus.i_data[7:0] = 8'h42;
    #1 check("t1_tx_stb", bus.o_tx_stb, 1);
    check("t1_byte_a", bus.o_tx_data, 8'h41);
    @(negedge clk);
    bus.i_data[7:0] = 8'h0a;
    #1 check("t1_byte_b", bus.o_tx_data, 8'h42);
    @(negedge clk);
    bus.i_stb[0] = 1'b0;
    #1 check("t1_byte_nl", bus.o_tx_data, 8'h0a);
    check("t1_released", bus.o_grant, 0);
    check("t1_state_idle", state, IDLE);
    @(negedge clk); #1;
    check("t1_drained", bus.o_tx_stb, 0);
    model_last = 0;

    // Both sources continuously requesting 3-byte CR lines
    for (int i = 0; i < 4; i++) begin
      add_line(0, 2, PP_CR);
      add_line(1, 2, PP_CR);
    end
    model_build();
    run_stream(0, -1, 2000);

    // Random line lengths and terminators under random transmitter back-pressure
    for (int i = 0; i < 6; i++) begin
      add_line(0, $urandom_range(0, 10), ($urandom_range(1) != 0) ? PP_NL : PP_CR);
      add_line(1, $urandom_range(0, 10), ($urandom_range(1) != 0) ? PP_NL : PP_CR);
    end
    model_build();
    run_stream(40, -1, 4000);

    // 100 unterminated bytes from source 1 force a MAXLEN release
    add_line(1, 100, PP_NL);
    add_line(0, 5, PP_NL);
    add_line(0, 5, PP_CR);
    model_build();
    run_stream(20, -1, 4000);

    // Five-cycle transmitter stall mid-line
    add_line(0, 20, PP_NL);
    model_build();
    run_stream(0, 5, 500);

    // Asynchronous reset while a byte sits in the output register
    bus.i_stb[1] = 1'b1; bus.i_data[15:8] = 8'h55;
    waited = 0;
    do begin
      @(negedge clk);
      #1 waited++;
    end while (!bus.o_tx_stb && waited < 20);
    check("t5_reached_tx", bus.o_tx_stb, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_tx_stb", bus.o_tx_stb, 0);
    check("t5_rst_tx_data", bus.o_tx_data, 0);
    check("t5_rst_grant", bus.o_grant, 0);
    check("t5_rst_busy", bus.o_busy, 2'b11);
    bus.i_stb = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_last = NSRC - 1;
    add_line(0, 3, PP_NL);
    add_line(1, 3, PP_NL);
    model_build();
    run_stream(30, -1, 1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pptx_arbiter.md
# pptx_arbiter

Shares the single pport transmit channel (to the Pi) among several byte-stream sources: line buffers, status reporters, and test pattern generators. It grants one source at a time, holds that grant for a whole line, then rotates round-robin, so lines from different sources never interleave. It sits between the sources and the pport transmit interface (stb/data/busy).

## Interface
- NSRC, 2: number of sources, 2..8.
- MAXLEN, 80: maximum bytes per grant before a forced release.
- TIMEOUT, 1024: idle cycles before a forced release; used only with PPARB_TIMEOUT_EN.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  reset; asynchronous, active-low
- i_stb  in  NSRC  per-source byte valid; held with data until accepted
- i_data  in  8*NSRC  source k byte on [8k+7:8k]
- o_busy  out  NSRC  source k byte accepted on a cycle with i_stb[k] && !o_busy[k]
- o_grant  out  NSRC  one-hot current owner, registered; all zero when idle
- o_tx_stb  out  1  byte valid to pport transmitter, registered
- o_tx_data  out  8  byte to pport transmitter, registered
- i_tx_busy  in  1  pport transmitter busy; byte taken on o_tx_stb && !i_tx_busy

## Operation
- Reset (asynchronous, i_reset_n low):
  - state IDLE; o_grant=0, o_tx_stb=0, o_tx_data=0, o_busy all ones.
  - byte counter 0; last-owner pointer NSRC-1, so source 0 has first priority.
  - Any byte held in the output register is discarded.
- Output register "free" = !o_tx_stb || !i_tx_busy.
- o_busy[k] = !(state==OWN && o_grant[k] && free). This is combinational on i_tx_busy.
- IDLE:
  - If any i_stb is set, pick the first requester after the last owner, in ascending index order with wraparound.
  - Set o_grant, clear the counter, go to OWN.
  - With no requests, stay in IDLE.
- OWN, on acceptance of owner byte b:
  - Load o_tx_data=b and o_tx_stb=1; increment the counter.
  - Release if b==8'h0a, b==8'h0d, or the counter reaches MAXLEN.
- OWN, free with no owner byte: o_tx_stb goes to 0 once the current byte is taken.
- Release:
  - Occurs on the edge that accepts the terminating byte.
  - Next state IDLE, o_grant=0, last-owner pointer = released owner.
  - The terminating byte still drains normally from the output register.
- Non-owners see o_busy=1 at all times.
- Requester dropping i_stb mid-line: grant is kept, unless PPARB_TIMEOUT_EN is set.
- Counter width: $clog2(MAXLEN+1). It saturates and never wraps.

## Timing
- i_stb[k] set in IDLE at cycle t: o_grant[k] at t+1, first byte accepted at the end of t+1 if free, o_tx_stb at t+2.
- Sustained throughput: one byte per cycle while i_tx_busy is low.
- i_tx_busy high with o_tx_stb high: o_tx_data and o_tx_stb hold; owner sees o_busy=1.
- Terminator accepted at edge t: IDLE during t+1, next grant visible at t+2. This one-cycle dead gap is mandatory.
- Simultaneous requests: strict round-robin from the last owner. The released source has the lowest priority in the next arbitration.

## Configuration
- PPARB_TIMEOUT_EN defined:
  - An idle counter runs in OWN. It clears on each owner byte accepted and counts cycles where the owner's i_stb is low.
  - On reaching TIMEOUT, release exactly as for a terminator, with no byte emitted.
  - Counter width: $clog2(TIMEOUT+1).
- PPARB_TIMEOUT_EN undefined:
  - No idle counter; the grant is held until a terminator or MAXLEN.
  - The TIMEOUT parameter is ignored.

## Structure
- Package pparb_pkg holds:
  - state typedef (IDLE, OWN);
  - constants PP_NL=8'h0a and PP_CR=8'h0d.
- Sub-module pparb_rrpick: combinational round-robin picker. Inputs: request vector and last-owner index. Outputs: one-hot grant and valid. Parameterised by NSRC.
- The top level holds the FSM, counters, and output register.

## Test plan
- Reset, then source 0 sends "AB\n" with i_tx_busy=0 → o_tx_data 8'h41, 8'h42, 8'h0a on consecutive cycles from t+2; o_grant=0 after the 8'h0a is accepted.
- Both sources request continuously, 3-byte lines ending 8'h0d → grants alternate 0,1,0,1 with a one-cycle gap; bytes never interleave.
- Source 1 sends 100 bytes with no terminator, MAXLEN=80 → release after byte 80; source 0 granted next if requesting; source 1's remaining 20 bytes go in a later grant.
- i_tx_busy held high for 5 cycles mid-line → o_tx_data stable, owner o_busy=1 for all 5 cycles, no byte lost or duplicated.
- i_reset_n pulsed low mid-line while o_tx_stb=1 → outputs 0 immediately; after release, source 0 wins the first arbitration.
- With PPARB_TIMEOUT_EN and TIMEOUT=16, owner stalls after 2 bytes → o_grant clears 16 cycles after the last acceptance; a waiting source is granted one cycle later.
